ram_loader: RTL

- Boot-time loader that sits directly upstream of the ram block and owns its in/address/load port during a load.
- Receives a byte stream over a valid/ready handshake and assembles bytes little-endian into words.
- Writes the words to consecutive addresses from 0, then reads every word back through ram's 1-cycle synchronous read port and checks it against a running checksum.
- While idle or done, the CPU's memory port passes straight through to ram.

---
 rtl/ram_loader_pkg.sv | 20 ++
 rtl/ram_loader_byte_packer.sv | 57 +++++
 rtl/ram_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the boot-time RAM loader: default memory geometry,
// loader state encodings and a width helper.
package ram_loader_pkg;

    localparam int DefaultAddrSize = 4;
    localparam int DefaultWordSize = 16;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_RECV   = 3'd1,
        LDR_WRITE  = 3'd2,
        LDR_VERIFY = 3'd3,
        LDR_DONE   = 3'd4
    } ldr_state_e;

    function automatic int bytes_for_width(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/ram_loader_byte_packer.sv
// Assembles a little-endian byte stream into words: the first byte of a word
// lands in bits [7:0]. word_valid flags the accept that completes a word.
module ram_loader_byte_packer
    import ram_loader_pkg::*;
#(
    parameter int WordSize     = DefaultWordSize,
    parameter int BytesPerWord = bytes_for_width(WordSize)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                accept,
    input  logic [7:0]          byte_in,
    output logic [WordSize-1:0] word,
    output logic                word_valid
);

    localparam int BufW = BytesPerWord * 8;
    localparam int CntW = $clog2(BytesPerWord + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BytesPerWord - 1);

    logic [BufW-1:0] buf_q, buf_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [BufW+7:0] shifted_s;

    // Shift new bytes in from the top so byte 0 ends up at the bottom.
    always_comb begin
        shifted_s = {byte_in, buf_q};
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        if (clear) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            buf_d = shifted_s[BufW+7:8];
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
        end else begin
            buf_d = buf_q;
            cnt_d = cnt_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign word       = buf_q[WordSize-1:0];
    assign word_valid = accept && !clear && (cnt_q == LastCnt);

endmodule

// File: rtl/ram_loader.sv
// Boot-time loader: streams bytes into words, writes them to RAM from address 0,
// reads them back to verify the checksum, and otherwise passes the CPU port through.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int AddrSize     = DefaultAddrSize,
    parameter int WordSize     = DefaultWordSize,
    parameter int BytesPerWord = bytes_for_width(WordSize)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AddrSize:0]   num_words,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic [WordSize-1:0] cpu_in,
    input  logic [AddrSize-1:0] cpu_address,
    input  logic                cpu_load,
    output logic [WordSize-1:0] ram_in,
    output logic [AddrSize-1:0] ram_address,
    output logic                ram_load,
    input  logic [WordSize-1:0] ram_out,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [WordSize-1:0] checksum
);

    localparam int CW = AddrSize + 1;
    localparam logic [CW-1:0] MaxWords = {1'b1, {AddrSize{1'b0}}};

    ldr_state_e          state_q, state_d;
    logic [CW-1:0]       n_q, n_d;
    logic [CW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic [WordSize-1:0] rb_sum_q, rb_sum_d;
    logic [WordSize-1:0] checksum_q, checksum_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                byte_ready_q, byte_ready_d;

    logic                accept_s;
    logic                clear_s;
    logic                word_valid_s;
    logic [WordSize-1:0] word_s;
    logic [CW-1:0]       n_clamp_s;
    logic [WordSize-1:0] rb_final_s;

    assign accept_s = byte_valid && byte_ready_q;
    assign clear_s  = (state_q != LDR_RECV);

    ram_loader_byte_packer #(
        .WordSize    (WordSize),
        .BytesPerWord(BytesPerWord)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .accept    (accept_s),
        .byte_in   (byte_in),
        .word      (word_s),
        .word_valid(word_valid_s)
    );

    assign n_clamp_s  = (num_words > MaxWords) ? MaxWords : num_words;
    assign rb_final_s = rb_sum_q + ram_out;

    // Next-state logic for the load sequence, pointers and checksums.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rb_sum_d   = rb_sum_q;
        checksum_d = checksum_q;
        error_d    = error_q;
        case (state_q)
            LDR_IDLE, LDR_DONE: begin
                if (start) begin
                    n_d        = n_clamp_s;
                    wr_ptr_d   = '0;
                    checksum_d = '0;
                    error_d    = 1'b0;
                    state_d    = (n_clamp_s == '0) ? LDR_DONE : LDR_RECV;
                end else begin
                    state_d = state_q;
                end
            end
            LDR_RECV: begin
                if (word_valid_s) begin
                    state_d = LDR_WRITE;
                end else begin
                    state_d = LDR_RECV;
                end
            end
            LDR_WRITE: begin
                checksum_d = checksum_q + word_s;
                wr_ptr_d   = wr_ptr_q + CW'(1);
                if (wr_ptr_q + CW'(1) == n_q) begin
                    state_d    = LDR_VERIFY;
                    rd_ptr_d   = '0;
                    rd_valid_d = 1'b0;
                    rb_sum_d   = '0;
                end else begin
                    state_d = LDR_RECV;
                end
            end
            LDR_VERIFY: begin
                // ram_out trails the presented address by one cycle, so the last
                // word arrives on the extra cycle where rd_ptr equals N.
                rd_ptr_d   = rd_ptr_q + CW'(1);
                rd_valid_d = (rd_ptr_q < n_q);
                rb_sum_d   = rd_valid_q ? rb_final_s : rb_sum_q;
                if (rd_ptr_q == n_q) begin
                    state_d = LDR_DONE;
                    error_d = (rb_final_s != checksum_q);
                end else begin
                    state_d = LDR_VERIFY;
                end
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase
        byte_ready_d = (state_d == LDR_RECV);
        busy_d       = (state_d == LDR_RECV) || (state_d == LDR_WRITE) ||
                       (state_d == LDR_VERIFY);
        done_d       = (state_d == LDR_DONE);
    end

    // Loader FSM state, datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LDR_IDLE;
            n_q          <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_valid_q   <= 1'b0;
            rb_sum_q     <= '0;
            checksum_q   <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_valid_q   <= rd_valid_d;
            rb_sum_q     <= rb_sum_d;
            checksum_q   <= checksum_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    // RAM port ownership: the loader while busy, the CPU otherwise.
    always_comb begin
        ram_in      = cpu_in;
        ram_address = cpu_address;
        ram_load    = cpu_load;
        case (state_q)
            LDR_WRITE: begin
                ram_in      = word_s;
                ram_address = wr_ptr_q[AddrSize-1:0];
                ram_load    = 1'b1;
            end
            LDR_VERIFY: begin
                ram_in      = '0;
                ram_address = rd_ptr_q[AddrSize-1:0];
                ram_load    = 1'b0;
            end
            LDR_RECV: begin
                ram_in      = '0;
                ram_address = wr_ptr_q[AddrSize-1:0];
                ram_load    = 1'b0;
            end
            default: begin
                ram_in      = cpu_in;
                ram_address = cpu_address;
                ram_load    = cpu_load;
            end
        endcase
    end

    assign byte_ready = byte_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign checksum   = checksum_q;

endmodule
